// File: rtl/dbp_ctrl_if.sv
// rtl/dbp_ctrl_if.sv - fetch, resolve and BHT signal bundle for dbp_ctrl
//
// Purpose: groups every non-clock/reset signal of the branch predictor
// controller. The slave modport is the controller's view. The master modport
// is the view of its surroundings: the fetch stage, the resolve stage and the
// two-port branch-history/target RAM.
// Ports (signals):
//   fetch_valid/fetch_pc                    fetch request
//   pred_valid/pred_pc/pred_taken/pred_target  prediction, 1 cycle later
//   upd_valid/upd_ready/upd_pc/upd_taken/upd_target  resolved-branch update
//   bht_add1/bht_rdata1                     BHT read port (fetch side)
//   bht_add2/bht_rdata2/bht_wen2/bht_wdata2 BHT read/write port (update side)
interface dbp_ctrl_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);
  logic              fetch_valid;
  logic [31:0]       fetch_pc;
  logic              pred_valid;
  logic [31:0]       pred_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              upd_valid;
  logic              upd_ready;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic [AWIDTH-1:0] bht_add1;
  logic [DWIDTH-1:0] bht_rdata1;
  logic [AWIDTH-1:0] bht_add2;
  logic [DWIDTH-1:0] bht_rdata2;
  logic              bht_wen2;
  logic [DWIDTH-1:0] bht_wdata2;

  modport slave (
    input  fetch_valid, fetch_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  bht_rdata1, bht_rdata2,
    output pred_valid, pred_pc, pred_taken, pred_target,
    output upd_ready,
    output bht_add1, bht_add2, bht_wen2, bht_wdata2
  );

  modport master (
    output fetch_valid, fetch_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output bht_rdata1, bht_rdata2,
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  upd_ready,
    input  bht_add1, bht_add2, bht_wen2, bht_wdata2
  );
endinterface

// File: rtl/dbp_ctrl.sv
// rtl/dbp_ctrl.sv - dynamic branch predictor controller
//
// Purpose: the fetch side looks up a 2-bit counter and target in the BHT and
// returns a prediction one cycle later. The resolve side read-modify-writes
// the entry over three cycles (IDLE -> RD -> WR). When a fetch samples the
// same index on the edge where the update commits, the freshly written entry
// is forwarded to the fetch.
// Ports:
//   clk    in  clock, all logic on posedge
//   reset  in  synchronous active-low reset
//   bus    dbp_ctrl_if.slave: fetch/pred, upd handshake, BHT ports 1 and 2
// Entry layout: {tgt[31:2], ctr[1:0]}.
module dbp_ctrl #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  dbp_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state;
  logic              upd_ready_q;
  logic [AWIDTH-1:0] add2_q;
  logic              wen_q;
  logic              upd_tk;
  logic [29:0]       upd_tgt;
  logic              pred_valid_q;
  logic [31:0]       pred_pc_q;
  logic              byp;
  logic [DWIDTH-1:0] byp_data;

  logic [AWIDTH-1:0] add1;
  logic [DWIDTH-1:0] entry;
  logic              wen;
  logic [1:0]        old_ctr;
  logic [1:0]        new_ctr;
  logic [29:0]       new_tgt;
  logic [DWIDTH-1:0] wdata;
  logic              unused_bits;

  // Only the index bits of upd_pc and the upper bits of upd_target matter.
  assign unused_bits = ^{bus.upd_pc, bus.upd_target[1:0]};

  assign add1 = bus.fetch_pc[AWIDTH+1:2];

  // The write is gated by reset, so nothing reaches the BHT on a reset cycle,
  // even when reset lands in the WR cycle itself.
  assign wen = wen_q & reset;

  // Port 2 data arrives during WR, so the new entry is formed from it then.
  // It is stable for the whole WR cycle because the RAM output is registered.
  always_comb begin
    old_ctr = bus.bht_rdata2[1:0];
    new_ctr = old_ctr;
    new_tgt = bus.bht_rdata2[31:2];
    if (upd_tk) begin
      new_ctr = (old_ctr == 2'd3) ? 2'd3 : old_ctr + 2'd1;
      new_tgt = upd_tgt;
    end else begin
      new_ctr = (old_ctr == 2'd0) ? 2'd0 : old_ctr - 2'd1;
    end
  end

  assign wdata = wen ? {new_tgt, new_ctr} : '0;

  assign entry = byp ? byp_data : bus.bht_rdata1;

  assign bus.bht_add1    = add1;
  assign bus.bht_add2    = add2_q;
  assign bus.bht_wen2    = wen;
  assign bus.bht_wdata2  = wdata;
  assign bus.upd_ready   = upd_ready_q;
  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_pc     = pred_pc_q;
  // Gating with pred_valid holds the prediction outputs at zero after reset.
  assign bus.pred_taken  = pred_valid_q & entry[1];
  assign bus.pred_target = !pred_valid_q ? 32'h0 :
                           entry[1] ? {entry[31:2], 2'b00} : pred_pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      upd_ready_q  <= 1'b0;
      add2_q       <= '0;
      wen_q        <= 1'b0;
      upd_tk       <= 1'b0;
      upd_tgt      <= '0;
      pred_valid_q <= 1'b0;
      pred_pc_q    <= '0;
      byp          <= 1'b0;
      byp_data     <= '0;
    end else begin
      pred_valid_q <= bus.fetch_valid;
      pred_pc_q    <= bus.fetch_pc;

      // The RAM returns pre-write data for this index, so the entry being
      // committed on this edge is captured for the fetch.
      byp <= wen && (add2_q == add1);
      if (wen && (add2_q == add1)) begin
        byp_data <= wdata;
      end

      case (state)
        IDLE: begin
          if (bus.upd_valid && upd_ready_q) begin
            add2_q      <= bus.upd_pc[AWIDTH+1:2];
            upd_tk      <= bus.upd_taken;
            upd_tgt     <= bus.upd_target[31:2];
            upd_ready_q <= 1'b0;
            state       <= RD;
          end else begin
            upd_ready_q <= 1'b1;
          end
        end
        RD: begin
          wen_q <= 1'b1;
          state <= WR;
        end
        WR: begin
          wen_q       <= 1'b0;
          upd_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          wen_q       <= 1'b0;
          upd_ready_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
